apb_rr_master: RTL and testbench

//  Round-robin APB master. Shares one APB slave (e.g. the APB memory) among NUM_REQ
//  on-chip requesters. Each requester issues single read/write commands over a

---
 rtl/apb_rr_master.sv | 200 ++++++++++++++++++++
 tb/tb_apb_rr_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ single-command requesters onto one
// APB slave, sequences SETUP/ACCESS phases, bounds the wait on pready with an
// optional timeout, and returns a registered one-cycle response to the winner.
module apb_rr_master #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          psel,
  output logic                          penable,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;        // last winner, also owner of the transfer in flight
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  // Arbiter outputs and the command fields of the current winner.
  logic                    any_valid;
  logic [PTR_W-1:0]        win_idx;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    win_write;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic [NUM_REQ-1:0]      owner_oh;
  logic                    timed_out;

  // Round-robin search starting one past the last winner.
  always_comb begin : arbiter
    logic [PTR_W:0] cand_w;
    any_valid = 1'b0;
    win_idx   = ptr_q;
    cand_w    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_w = {1'b0, ptr_q} + (PTR_W + 1)'(off);
      if (cand_w >= (PTR_W + 1)'(NUM_REQ)) begin
        cand_w = cand_w - (PTR_W + 1)'(NUM_REQ);
      end
      if (!any_valid && req_valid[cand_w[PTR_W-1:0]]) begin
        any_valid = 1'b1;
        win_idx   = cand_w[PTR_W-1:0];
      end
    end
  end

  // Select the winner's command fields from the flattened request buses.
  always_comb begin
    win_addr  = '0;
    win_write = 1'b0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_write = req_write[i];
        win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // One-hot owner and timeout detect for the transfer in flight.
  always_comb begin
    owner_oh  = NUM_REQ'(1) << ptr_q;
    timed_out = (TIMEOUT > 0) && (timer_q == TMR_W'(TIMEOUT - 1));
  end

  // Next-state, APB phase outputs, grant and response generation.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    req_ready   = '0;
    psel        = 1'b0;
    penable     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_valid && !rst) begin
          req_ready[win_idx] = 1'b1;
          ptr_d   = win_idx;
          addr_d  = win_addr;
          write_d = win_write;
          wdata_d = win_wdata;
          timer_d = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        psel    = 1'b1;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // An X/Z pready fails this test and is treated as not ready.
        if (pready == 1'b1) begin
          rsp_valid_d = owner_oh;
          rsp_rdata_d = write_q ? '0 : prdata;
          if (any_valid && !rst) begin
            // Back-to-back: hand the bus to the next winner without an idle cycle.
            req_ready[win_idx] = 1'b1;
            ptr_d   = win_idx;
            addr_d  = win_addr;
            write_d = win_write;
            wdata_d = win_wdata;
            timer_d = '0;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timed_out) begin
          rsp_valid_d = owner_oh;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, latched command and response registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the command registers drive paddr/pwrite/pwdata directly, so they
      // are reset too; otherwise the APB outputs would not read 0 after reset.
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      timer_q     <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign paddr     = addr_q;
  assign pwrite    = write_q;
  assign pwdata    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: a memory-backed APB slave with programmable wait
// states, a table of single-command vectors, hand sequences for back-to-back
// arbitration and mid-transfer reset, and a randomized phase against a
// transaction-level round-robin/memory model.
module tb_apb_rr_master;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic [AW-1:0]     paddr;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready;

  apb_rr_master #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // APB memory slave; a wait setting of -1 means never ready.
  bit [DW-1:0] mem [256];
  int          fixed_wait = 0;
  int          rnd_wait   = 0;
  bit          use_rnd    = 1'b0;
  int          acc_cnt    = 0;
  int          eff_wait;

  assign eff_wait = use_rnd ? rnd_wait : fixed_wait;
  assign pready   = psel && penable && (eff_wait >= 0) && (acc_cnt == eff_wait);
  assign prdata   = mem[paddr];

  always @(posedge clk) begin
    if (psel && penable && pready) begin
      if (pwrite) mem[paddr] <= pwdata;
      acc_cnt  <= 0;
      rnd_wait <= int'($urandom_range(0, 3));
    end else if (psel && penable) begin
      acc_cnt <= acc_cnt + 1;
    end else begin
      acc_cnt <= 0;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    if (i < 0) return '0;
    return NR'(1) << i;
  endfunction

  // Round-robin rule: first valid requester after ptr, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] vld, input int ptr);
    for (int off = 1; off <= NR; off++) begin
      if (vld[(ptr + off) % NR]) return (ptr + off) % NR;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          idx;
    bit          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int          waits;
    logic [DW-1:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int  n;
    int  gcyc;
    int  acc;
    bit  stable;
    fixed_wait = v.waits;
    @(negedge clk);
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    req_write[v.idx] = v.write;
    req_addr[v.idx*AW +: AW]  = v.addr;
    req_wdata[v.idx*DW +: DW] = v.wdata;
    #1;
    n = 0;
    while (!req_ready[v.idx] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("vec_grant", (n < 20), 1);
    gcyc = cyc;
    @(negedge clk);
    req_valid = '0;
    check("vec_setup_phase", {psel, penable}, 2'b10);
    @(negedge clk);
    check("vec_access_phase", {psel, penable}, 2'b11);
    acc = 0;
    stable = 1'b1;
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      if (penable) acc++;
      if (psel && (paddr != v.addr || pwrite != v.write || (v.write && pwdata != v.wdata)))
        stable = 1'b0;
      @(negedge clk);
      n++;
    end
    check("vec_rsp_seen", (n < 40), 1);
    check("vec_rsp_valid", rsp_valid, onehot(v.idx));
    check("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
    check("vec_rsp_err", rsp_err, v.exp_err);
    check("vec_latency", cyc - gcyc, v.exp_lat);
    check("vec_access_cycles", acc, v.exp_acc);
    check("vec_apb_stable", stable, 1);
    if (v.exp_err) check("vec_psel_drop", psel, 0);
    @(negedge clk);
    check("vec_rsp_pulse", rsp_valid, '0);
  endtask

  typedef struct {
    int            idx;
    bit            write;
    logic [DW-1:0] rdata;
  } exp_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [8];
    exp_t          q [$];
    exp_t          e;
    bit [DW-1:0]   ref_mem [256];
    logic [NR-1:0] vld, outst, clr;
    logic [NR-1:0] w_arr;
    logic [AW-1:0] a_arr [NR];
    logic [DW-1:0] d_arr [NR];
    int            mptr;
    int            win;
    int            g_idx [8];
    int            g_cyc [8];
    int            r_cyc [8];
    int            ng, nr, npsel, nrsp;
    logic [NR-1:0] clr3;

    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;

    // idx, write, addr, wdata, waits, exp_rdata, exp_err, exp_lat, exp_acc
    vecs[0] = '{0, 1'b1, 8'h05, 32'hDEADBEEF,  0, 32'h00000000, 1'b0,  3,  1};
    vecs[1] = '{2, 1'b0, 8'h05, 32'h00000000,  0, 32'hDEADBEEF, 1'b0,  3,  1};
    vecs[2] = '{1, 1'b1, 8'h10, 32'h12345678,  3, 32'h00000000, 1'b0,  6,  4};
    vecs[3] = '{3, 1'b0, 8'h10, 32'h00000000,  3, 32'h12345678, 1'b0,  6,  4};
    vecs[4] = '{1, 1'b0, 8'h05, 32'h00000000, -1, 32'h00000000, 1'b1, 18, 16};
    vecs[5] = '{2, 1'b1, 8'h20, 32'hA5A5A5A5,  1, 32'h00000000, 1'b0,  4,  2};
    vecs[6] = '{0, 1'b0, 8'h20, 32'h00000000,  2, 32'hA5A5A5A5, 1'b0,  5,  3};
    vecs[7] = '{3, 1'b0, 8'h7F, 32'h00000000,  0, 32'h00000000, 1'b0,  3,  1};
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // All four requesters valid after reset: grants 0,1,2,3 back-to-back.
    do_reset();
    fixed_wait = 0;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      req_write[i] = 1'b1;
      req_addr[i*AW +: AW]  = AW'(8'h40 + i);
      req_wdata[i*DW +: DW] = DW'(32'hC0DE0000 + i);
    end
    req_valid = '1;
    ng = 0; nr = 0; npsel = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      clr3 = req_ready;
      if (req_ready != '0 && ng < 8) begin
        g_idx[ng] = $clog2(req_ready);
        g_cyc[ng] = cyc;
        ng++;
      end
      if (psel) npsel++;
      if (rsp_valid != '0 && nr < 8) begin
        r_cyc[nr] = cyc;
        nr++;
      end
      @(negedge clk);
      req_valid = req_valid & ~clr3;
    end
    check("b2b_grant_count", ng, 4);
    check("b2b_rsp_count", nr, 4);
    check("b2b_psel_cycles", npsel, 8);
    if (ng == 4 && nr == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("b2b_grant_order", g_idx[k], k);
        check("b2b_grant_cycle", g_cyc[k] - g_cyc[0], 2 * k);
        check("b2b_rsp_cycle", r_cyc[k] - g_cyc[0], 2 * k + 3);
      end
    end

    // Reset pulsed during ACCESS: transfer dropped silently, req0 wins next.
    do_reset();
    fixed_wait = -1;
    @(negedge clk);
    req_write[1] = 1'b0;
    req_addr[1*AW +: AW] = 8'h33;
    req_valid = 4'b0010;
    #1;
    check("rstmid_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_in_access", {psel, penable}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_apb_idle", {psel, penable}, 2'b00);
    check("rstmid_no_rsp", rsp_valid, '0);
    rst = 1'b0;
    nrsp = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid != '0) nrsp++;
    end
    check("rstmid_no_late_rsp", nrsp, 0);
    req_valid = 4'b1001;
    #1;
    check("rstmid_req0_first", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    repeat (25) @(negedge clk);

    // Randomized traffic against the transaction-level model.
    do_reset();
    use_rnd = 1'b1;
    mptr  = NR - 1;
    vld   = '0;
    outst = '0;
    clr   = '0;
    w_arr = '0;
    for (int i = 0; i < NR; i++) begin
      a_arr[i] = '0;
      d_arr[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      vld = vld & ~clr;
      for (int i = 0; i < NR; i++) begin
        if (c < 2500 && !vld[i] && !outst[i] && $urandom_range(0, 3) == 0) begin
          vld[i]   = 1'b1;
          w_arr[i] = 1'($urandom);
          a_arr[i] = 8'h80 | AW'($urandom_range(0, 127));
          d_arr[i] = $urandom;
        end else if (vld[i] && $urandom_range(0, 31) == 0) begin
          vld[i] = 1'b0;
        end
      end
      for (int i = 0; i < NR; i++) begin
        req_write[i] = w_arr[i];
        req_addr[i*AW +: AW]  = a_arr[i];
        req_wdata[i*DW +: DW] = d_arr[i];
      end
      req_valid = vld;
      #1;
      clr = req_ready;
      if (req_ready != '0) begin
        win = rr_pick(vld, mptr);
        check("rnd_rr_grant", req_ready, onehot(win));
        if (win >= 0) begin
          mptr       = win;
          outst[win] = 1'b1;
          e.idx   = win;
          e.write = w_arr[win];
          e.rdata = w_arr[win] ? '0 : ref_mem[a_arr[win]];
          if (w_arr[win]) ref_mem[a_arr[win]] = d_arr[win];
          q.push_back(e);
        end
      end
      if (rsp_valid != '0) begin
        if (q.size() == 0) begin
          check("rnd_unexpected_rsp", rsp_valid, '0);
        end else begin
          e = q.pop_front();
          check("rnd_rsp_owner", rsp_valid, onehot(e.idx));
          check("rnd_rsp_rdata", rsp_rdata, e.rdata);
          check("rnd_rsp_err", rsp_err, 0);
          outst[e.idx] = 1'b0;
        end
      end
    end
    check("rnd_drained", q.size(), 0);
    check("rnd_no_outstanding", outst, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
